// File: rtl/vga_dac.sv
// VGA palette DAC: CPU-programmable 256 x 18-bit palette driving a 2-stage pixel lookup pipeline.
// Latency: pixel path is a fixed 2 cycles colour_i -> RGB; CPU reads return data the cycle after the strobe.
// Backpressure: none; the pixel path never stalls and CPU strobes are single-cycle, always accepted.
module vga_dac (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       reg_wr_i,
    input  logic       reg_rd_i,
    input  logic [1:0] reg_addr_i,
    input  logic [7:0] reg_data_i,
    output logic [7:0] reg_data_o,
    input  logic       de_i,
    input  logic [7:0] colour_i,
    output logic [5:0] red_o,
    output logic [5:0] green_o,
    output logic [5:0] blue_o
);

    localparam logic [1:0] ADDR_MASK  = 2'd0;
    localparam logic [1:0] ADDR_RIDX  = 2'd1;
    localparam logic [1:0] ADDR_WIDX  = 2'd2;
    localparam logic [1:0] ADDR_DATA  = 2'd3;

    // Palette storage, deliberately left out of reset so contents survive it
    logic [17:0] pal_mem [0:255];

    logic [7:0] pel_mask_q, pel_mask_d;
    logic [7:0] windex_q,   windex_d;
    logic [7:0] rindex_q,   rindex_d;
    logic [1:0] comp_q,     comp_d;
    logic [5:0] temp_r_q,   temp_r_d;
    logic [5:0] temp_g_q,   temp_g_d;
    logic       mode_q,     mode_d;
    logic [7:0] rdata_q,    rdata_d;

    logic [7:0] pix_addr_q, pix_addr_d;
    logic       pix_de_q,   pix_de_d;
    logic [5:0] red_q,      red_d;
    logic [5:0] green_q,    green_d;
    logic [5:0] blue_q,     blue_d;

    logic        cpu_wr;
    logic        cpu_rd;
    logic        pal_we;
    logic [17:0] pal_wdata;
    logic [17:0] pal_rentry;
    logic [17:0] pix_entry;

    // Top data bits are meaningless to a 6-bit DAC
    logic unused_data_bits;
    assign unused_data_bits = ^reg_data_i[7:6];

    // Strobes are dead during reset; a write wins over a simultaneous read
    assign cpu_wr = reg_wr_i & ~reset_i;
    assign cpu_rd = reg_rd_i & ~reg_wr_i & ~reset_i;

    // CPU register file: index/component sequencing and read-data selection
    always_comb begin
        pel_mask_d = pel_mask_q;
        windex_d   = windex_q;
        rindex_d   = rindex_q;
        comp_d     = comp_q;
        temp_r_d   = temp_r_q;
        temp_g_d   = temp_g_q;
        mode_d     = mode_q;
        rdata_d    = rdata_q;
        pal_we     = 1'b0;
        pal_wdata  = {temp_r_q, temp_g_q, reg_data_i[5:0]};
        pal_rentry = pal_mem[rindex_q];

        if (cpu_wr) begin
            case (reg_addr_i)
                ADDR_MASK: pel_mask_d = reg_data_i;
                ADDR_RIDX: begin
                    rindex_d = reg_data_i;
                    comp_d   = 2'd0;
                    mode_d   = 1'b1;
                end
                ADDR_WIDX: begin
                    windex_d = reg_data_i;
                    comp_d   = 2'd0;
                    mode_d   = 1'b0;
                end
                default: begin
                    case (comp_q)
                        2'd0: begin
                            temp_r_d = reg_data_i[5:0];
                            comp_d   = 2'd1;
                        end
                        2'd1: begin
                            temp_g_d = reg_data_i[5:0];
                            comp_d   = 2'd2;
                        end
                        default: begin
                            pal_we   = 1'b1;
                            windex_d = windex_q + 8'd1;
                            comp_d   = 2'd0;
                        end
                    endcase
                end
            endcase
        end else if (cpu_rd) begin
            case (reg_addr_i)
                ADDR_MASK: rdata_d = pel_mask_q;
                ADDR_RIDX: rdata_d = {6'b0, mode_q, mode_q};
                ADDR_WIDX: rdata_d = windex_q;
                default: begin
                    case (comp_q)
                        2'd0: begin
                            rdata_d = {2'b00, pal_rentry[17:12]};
                            comp_d  = 2'd1;
                        end
                        2'd1: begin
                            rdata_d = {2'b00, pal_rentry[11:6]};
                            comp_d  = 2'd2;
                        end
                        default: begin
                            rdata_d  = {2'b00, pal_rentry[5:0]};
                            rindex_d = rindex_q + 8'd1;
                            comp_d   = 2'd0;
                        end
                    endcase
                end
            endcase
        end
    end

    // Pixel pipeline: stage 1 masks the index, stage 2 looks up the palette or blanks
    always_comb begin
        pix_addr_d = colour_i & pel_mask_q;
        pix_de_d   = de_i;
        pix_entry  = pal_mem[pix_addr_q];
        red_d      = 6'd0;
        green_d    = 6'd0;
        blue_d     = 6'd0;
        if (pix_de_q) begin
            red_d   = pix_entry[17:12];
            green_d = pix_entry[11:6];
            blue_d  = pix_entry[5:0];
        end
    end

    // Register state update with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pel_mask_q <= 8'hFF;
            windex_q   <= 8'd0;
            rindex_q   <= 8'd0;
            comp_q     <= 2'd0;
            temp_r_q   <= 6'd0;
            temp_g_q   <= 6'd0;
            mode_q     <= 1'b0;
            rdata_q    <= 8'd0;
            pix_addr_q <= 8'd0;
            pix_de_q   <= 1'b0;
            red_q      <= 6'd0;
            green_q    <= 6'd0;
            blue_q     <= 6'd0;
        end else begin
            pel_mask_q <= pel_mask_d;
            windex_q   <= windex_d;
            rindex_q   <= rindex_d;
            comp_q     <= comp_d;
            temp_r_q   <= temp_r_d;
            temp_g_q   <= temp_g_d;
            mode_q     <= mode_d;
            rdata_q    <= rdata_d;
            pix_addr_q <= pix_addr_d;
            pix_de_q   <= pix_de_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    // Palette write; a same-edge pixel lookup of this entry still sees the old value
    always_ff @(posedge clock_i) begin
        if (pal_we) begin
            pal_mem[windex_q] <= pal_wdata;
        end
    end

    assign reg_data_o = rdata_q;
    assign red_o      = red_q;
    assign green_o    = green_q;
    assign blue_o     = blue_q;

endmodule

// File: tb/tb_vga_dac.sv
// Testbench for vga_dac: directed register/pixel scenarios plus randomized traffic.
// Every cycle the outputs are compared against a behavioural palette/register model.
// Stimulus is applied 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_vga_dac;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       reg_wr_i = 1'b0;
    logic       reg_rd_i = 1'b0;
    logic [1:0] reg_addr_i = 2'd0;
    logic [7:0] reg_data_i = 8'd0;
    logic [7:0] reg_data_o;
    logic       de_i = 1'b0;
    logic [7:0] colour_i = 8'd0;
    logic [5:0] red_o, green_o, blue_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    vga_dac dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .reg_wr_i   (reg_wr_i),
        .reg_rd_i   (reg_rd_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .reg_data_o (reg_data_o),
        .de_i       (de_i),
        .colour_i   (colour_i),
        .red_o      (red_o),
        .green_o    (green_o),
        .blue_o     (blue_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Known starting colour for every entry, loaded through the CPU port
    function automatic logic [17:0] init_val(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b[5:0], ~b[5:0], b[7:2]};
    endfunction

    // ---------------- reference model ----------------
    logic [17:0] m_pal [256];
    logic [7:0]  m_mask = 8'hFF, m_wi = 8'd0, m_ri = 8'd0, m_rd = 8'd0;
    int          m_comp = 0;
    logic [5:0]  m_tr = 6'd0, m_tg = 6'd0;
    logic        m_mode = 1'b0;
    logic        m_pde = 1'b0;
    logic [7:0]  m_paddr = 8'd0;
    logic [17:0] m_pix = 18'd0;

    always @(posedge clock_i) begin
        logic [17:0] e;
        if (reset_i) begin
            m_mask = 8'hFF; m_wi = 8'd0; m_ri = 8'd0; m_rd = 8'd0;
            m_comp = 0; m_tr = 6'd0; m_tg = 6'd0; m_mode = 1'b0;
            m_pde = 1'b0; m_pix = 18'd0;
        end else begin
            // pixel that entered one edge ago is looked up in the palette as it stands before this edge
            m_pix   = m_pde ? m_pal[m_paddr] : 18'd0;
            m_pde   = de_i;
            m_paddr = colour_i & m_mask;
            if (reg_wr_i) begin
                case (reg_addr_i)
                    2'd0: m_mask = reg_data_i;
                    2'd1: begin m_ri = reg_data_i; m_comp = 0; m_mode = 1'b1; end
                    2'd2: begin m_wi = reg_data_i; m_comp = 0; m_mode = 1'b0; end
                    default: begin
                        if (m_comp == 0) m_tr = reg_data_i[5:0];
                        else if (m_comp == 1) m_tg = reg_data_i[5:0];
                        else begin
                            m_pal[m_wi] = {m_tr, m_tg, reg_data_i[5:0]};
                            m_wi = m_wi + 8'd1;
                        end
                        m_comp = (m_comp + 1) % 3;
                    end
                endcase
            end else if (reg_rd_i) begin
                case (reg_addr_i)
                    2'd0: m_rd = m_mask;
                    2'd1: m_rd = {6'b0, m_mode, m_mode};
                    2'd2: m_rd = m_wi;
                    default: begin
                        e = m_pal[m_ri] >> (6 * (2 - m_comp));
                        m_rd = {2'b00, e[5:0]};
                        if (m_comp == 2) m_ri = m_ri + 8'd1;
                        m_comp = (m_comp + 1) % 3;
                    end
                endcase
            end
        end
    end

    // Continuous comparison against the model
    always @(negedge clock_i) begin
        if (chk_en) begin
            check("red",   {2'b00, red_o},   {2'b00, m_pix[17:12]});
            check("green", {2'b00, green_o}, {2'b00, m_pix[11:6]});
            check("blue",  {2'b00, blue_o},  {2'b00, m_pix[5:0]});
            check("rdata", reg_data_o, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        reg_wr_i = 1'b1; reg_addr_i = a; reg_data_i = d;
        tick();
        reg_wr_i = 1'b0;
    endtask

    task automatic cpu_rd(input logic [1:0] a);
        reg_rd_i = 1'b1; reg_addr_i = a;
        tick();
        reg_rd_i = 1'b0;
    endtask

    task automatic pix(input logic d, input logic [7:0] c);
        de_i = d; colour_i = c;
        tick();
    endtask

    // Reset with a CPU write held active to show strobes are ignored
    task automatic do_reset();
        reset_i = 1'b1; reg_wr_i = 1'b1; reg_addr_i = 2'd0; reg_data_i = 8'h00;
        tick();
        reset_i = 1'b0; reg_wr_i = 1'b0;
    endtask

    task automatic check_rgb(input string tag, input logic [17:0] exp);
        check({tag, "_r"}, {2'b00, red_o},   {2'b00, exp[17:12]});
        check({tag, "_g"}, {2'b00, green_o}, {2'b00, exp[11:6]});
        check({tag, "_b"}, {2'b00, blue_o},  {2'b00, exp[5:0]});
    endtask

    logic [7:0]  wdat [6] = '{8'hC1, 8'h02, 8'h43, 8'h04, 8'h85, 8'h06};
    logic [17:0] v;

    initial begin
        // reset state
        do_reset();
        do_reset();
        chk_en = 1'b1;
        check("rst_rdata", reg_data_o, 8'h00);
        check_rgb("rst_rgb", 18'd0);
        cpu_rd(2'd0); check("rst_mask", reg_data_o, 8'hFF);
        cpu_rd(2'd1); check("rst_mode", reg_data_o, 8'h00);
        cpu_rd(2'd2); check("rst_widx", reg_data_o, 8'h00);

        // load a known colour into every entry
        cpu_wr(2'd2, 8'h00);
        for (int i = 0; i < 256; i++) begin
            v = init_val(i);
            cpu_wr(2'd3, {2'b00, v[17:12]});
            cpu_wr(2'd3, {2'b11, v[11:6]});
            cpu_wr(2'd3, {2'b01, v[5:0]});
        end
        cpu_rd(2'd2); check("init_widx_wrap", reg_data_o, 8'h00);

        // single triple write and 2-cycle pixel latency
        cpu_wr(2'd2, 8'h10);
        cpu_wr(2'd3, 8'h3F); cpu_wr(2'd3, 8'h00); cpu_wr(2'd3, 8'h15);
        cpu_rd(2'd2); check("widx_11", reg_data_o, 8'h11);
        pix(1'b1, 8'h10);
        check_rgb("lat1", init_val(8'h0F) & 18'd0);
        pix(1'b0, 8'h00);
        check_rgb("pix10", {6'h3F, 6'h00, 6'h15});

        // write index wrap from 0xFF to 0x00
        cpu_wr(2'd2, 8'hFF);
        for (int i = 0; i < 6; i++) cpu_wr(2'd3, wdat[i]);
        cpu_rd(2'd2); check("widx_wrap", reg_data_o, 8'h01);
        cpu_wr(2'd1, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            cpu_rd(2'd3);
            check("wrap_rd", reg_data_o, 8'(i + 1));
        end

        // read sequence and mode readback
        cpu_wr(2'd1, 8'h10);
        cpu_rd(2'd3); check("rd_r", reg_data_o, 8'h3F);
        cpu_rd(2'd3); check("rd_g", reg_data_o, 8'h00);
        cpu_rd(2'd3); check("rd_b", reg_data_o, 8'h15);
        cpu_rd(2'd1); check("mode_rd", reg_data_o, 8'h03);
        v = init_val(8'h11);
        cpu_rd(2'd3); check("rd_next", reg_data_o, {2'b00, v[17:12]});
        tick(); check("rd_hold", reg_data_o, {2'b00, v[17:12]});

        // pel mask and blanking
        cpu_wr(2'd0, 8'h0F);
        pix(1'b1, 8'hF3);
        pix(1'b0, 8'hF3);
        check_rgb("mask", init_val(8'h03));
        pix(1'b0, 8'h00);
        check_rgb("blank", 18'd0);

        // reset in the middle of a triple
        cpu_wr(2'd2, 8'h40);
        cpu_wr(2'd3, 8'h11); cpu_wr(2'd3, 8'h22);
        do_reset();
        cpu_wr(2'd3, 8'h33);
        cpu_rd(2'd0); check("mask_after_rst", reg_data_o, 8'hFF);
        cpu_rd(2'd2); check("widx_after_rst", reg_data_o, 8'h00);
        cpu_wr(2'd3, 8'h34); cpu_wr(2'd3, 8'h35);
        cpu_wr(2'd1, 8'h00);
        cpu_rd(2'd3); check("tr_kept", reg_data_o, 8'h33);
        cpu_rd(2'd3); cpu_rd(2'd3);
        cpu_wr(2'd1, 8'h40);
        v = init_val(8'h40);
        cpu_rd(2'd3); check("no_wr_r", reg_data_o, {2'b00, v[17:12]});
        cpu_rd(2'd3); check("no_wr_g", reg_data_o, {2'b00, v[11:6]});
        cpu_rd(2'd3); check("no_wr_b", reg_data_o, {2'b00, v[5:0]});

        // CPU final write and pixel lookup of 0x20 on the same edge
        cpu_wr(2'd2, 8'h20);
        cpu_wr(2'd3, 8'h01); cpu_wr(2'd3, 8'h02);
        pix(1'b1, 8'h20);
        reg_wr_i = 1'b1; reg_addr_i = 2'd3; reg_data_i = 8'h03;
        pix(1'b1, 8'h20);
        reg_wr_i = 1'b0;
        check_rgb("coll_old", init_val(8'h20));
        pix(1'b0, 8'h00);
        check_rgb("coll_new", {6'h01, 6'h02, 6'h03});

        // simultaneous write and read: read ignored
        cpu_rd(2'd0);
        reg_wr_i = 1'b1; reg_rd_i = 1'b1; reg_addr_i = 2'd0; reg_data_i = 8'h5A;
        tick();
        reg_wr_i = 1'b0; reg_rd_i = 1'b0;
        check("wr_rd_hold", reg_data_o, 8'hFF);
        cpu_rd(2'd0); check("wr_rd_mask", reg_data_o, 8'h5A);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset_i    = ($urandom_range(0, 399) == 0);
            reg_wr_i   = ($urandom_range(0, 3) == 0);
            reg_rd_i   = ($urandom_range(0, 2) == 0);
            reg_addr_i = 2'($urandom_range(0, 3));
            reg_data_i = 8'($urandom);
            de_i       = 1'($urandom_range(0, 1));
            colour_i   = 8'($urandom);
            tick();
        end
        reset_i = 1'b0; reg_wr_i = 1'b0; reg_rd_i = 1'b0; de_i = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_dac.md
VGA_DAC -- requirements
Module: vga_dac

Interface
REQ-001 SHALL have port clock_i, input, 1 bit: dot clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port reg_wr_i, input, 1 bit: CPU register write strobe, one cycle per access.
REQ-004 SHALL have port reg_rd_i, input, 1 bit: CPU register read strobe, one cycle per access.
REQ-005 SHALL have port reg_addr_i, input, 2 bits: register select; 0 = PEL mask, 1 = read index (write) / DAC state (read), 2 = write index, 3 = palette data.
REQ-006 SHALL have port reg_data_i, input, 8 bits: CPU write data.
REQ-007 SHALL have port reg_data_o, output, 8 bits: CPU read data, registered.
REQ-008 SHALL have port de_i, input, 1 bit: display enable, aligned with colour_i.
REQ-009 SHALL have port colour_i, input, 8 bits: palette index from the attribute controller.
REQ-010 SHALL have ports red_o, green_o and blue_o, outputs, 6 bits each: registered DAC levels.

Function
REQ-011 SHALL hold a 256 x 18-bit palette RAM, entry = {R[5:0], G[5:0], B[5:0]}, with one CPU port and one pixel read port.
REQ-012 SHALL hold the following registers: 8-bit pel_mask, 8-bit windex, 8-bit rindex, a 2-bit component counter comp (values 0..2, shared by reads and writes), 6-bit temp_r, 6-bit temp_g, and a 1-bit mode (0 = write, 1 = read).
REQ-013 SHALL, on reg_wr_i to address 0, load pel_mask from reg_data_i.
REQ-014 SHALL, on reg_wr_i to address 2, load windex, clear comp to 0 and clear mode to 0.
REQ-015 SHALL, on reg_wr_i to address 1, load rindex, clear comp to 0 and set mode to 1.
REQ-016 SHALL, on reg_wr_i to address 3, take reg_data_i[5:0] (bits 7:6 ignored) as follows: comp 0 -> temp_r, comp 1 -> temp_g, comp 2 -> write {temp_r, temp_g, data} to palette[windex].
REQ-017 SHALL, on the comp-2 write of REQ-016, increment windex modulo 256 (255 -> 0) and set comp to 0; otherwise comp SHALL increment by 1.
REQ-018 SHALL, on reg_rd_i to address 3, set reg_data_o next cycle to {2'b00, component comp of palette[rindex]} (0 = R, 1 = G, 2 = B).
REQ-019 SHALL, on the comp-2 read of REQ-018, increment rindex modulo 256 and set comp to 0; otherwise comp SHALL increment by 1.
REQ-020 SHALL return the following on other reads, each valid in reg_data_o the cycle after reg_rd_i: address 0 -> pel_mask; address 1 -> {6'b0, mode, mode}; address 2 -> windex.
REQ-021 SHALL hold reg_data_o unchanged in cycles without reg_rd_i.
REQ-022 SHALL, when reg_wr_i and reg_rd_i are high in the same cycle, perform the write and ignore the read, leaving reg_data_o unchanged.
REQ-023 SHALL implement the pixel path as a fixed 2-cycle latency pipeline.
REQ-024 SHALL, in pipeline stage 1, register addr = colour_i AND pel_mask together with de_i.
REQ-025 SHALL, in pipeline stage 2, register palette[addr] onto red_o/green_o/blue_o if the delayed de is high, else register zeros.
REQ-026 SHALL keep the pixel path independent of CPU activity: no stalls and no bubbles.
REQ-027 SHALL, when a CPU palette write and a pixel read hit the same entry in the same cycle, return the old entry to the pixel path; the new value SHALL be visible from the next cycle.
REQ-028 SHALL apply a pel_mask write to pixels entering stage 1 on the following cycle.

Reset
REQ-029 SHALL, on reset_i high at a clock edge, set pel_mask = 8'hFF, windex = rindex = 0, comp = 0, mode = 0, temp_r = temp_g = 0, reg_data_o = 0, red_o = green_o = blue_o = 0 and clear the pipeline de bits.
REQ-030 SHALL NOT clear palette RAM contents on reset.
REQ-031 SHALL abandon a partially completed RGB write triple on reset mid-sequence, with no RAM write.
REQ-032 SHALL ignore CPU strobes while reset_i is high.

Verification
REQ-033 SHALL cover: write index 0x10, data 0x3F, 0x00, 0x15 -> palette[0x10] = {3F,00,15}, windex = 0x11; then de = 1, colour_i = 0x10 -> red_o/green_o/blue_o = 3F/00/15 exactly 2 cycles later.
REQ-034 SHALL cover: write index 0xFF, 6 data writes -> entries 0xFF and 0x00 written, windex = 0x01 (wrap).
REQ-035 SHALL cover: read index 0x10, 3 data reads -> reg_data_o = 0x3F, 0x00, 0x15; rindex = 0x11; address-1 read returns 0x03.
REQ-036 SHALL cover: pel_mask = 0x0F, colour_i = 0xF3 -> entry 0x03 displayed; de = 0 -> outputs 0 two cycles later.
REQ-037 SHALL cover: two data writes then reset, then a third data write -> value lands in temp_r, no RAM write; pel_mask reads 0xFF.
REQ-038 SHALL cover: same-cycle CPU final write and pixel lookup of entry 0x20 -> old colour in that pixel, new colour in the next pixel.
